// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the load/store bus controller.
//   - lsOp access encodings and small decode helpers
//   - FSM state enumeration
//   - default bus-timeout length
package lsu_bus_ctrl_pkg;

  localparam logic [3:0] OP_LW  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LB  = 4'b0100;
  localparam logic [3:0] OP_LBU = 4'b0101;
  localparam logic [3:0] OP_SW  = 4'b0110;
  localparam logic [3:0] OP_SH  = 4'b0111;
  localparam logic [3:0] OP_SB  = 4'b1000;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SW) && (op <= OP_SB);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

  // Word accesses need addr[1:0]=00, halfword accesses need addr[0]=0.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = lo[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extractor.
// Selects the addressed halfword/byte from the raw bus word and sign- or
// zero-extends it according to the load type; lw passes through.
// Ports:
//   raw_i     [31:0] raw word read from the bus
//   op_i      [3:0]  lsOp of the load
//   addr_lo_i [1:0]  byte offset of the load address
//   data_o    [31:0] extended load result
module lsu_load_ext
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    half_v = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    byte_v = raw_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_v = raw_i[7:0];
      2'd1:    byte_v = raw_i[15:8];
      2'd2:    byte_v = raw_i[23:16];
      default: byte_v = raw_i[31:24];
    endcase

    data_o = raw_i;
    case (op_i)
      OP_LH:   data_o = {{16{half_v[15]}}, half_v};
      OP_LHU:  data_o = {16'h0000, half_v};
      OP_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data_o = {24'h000000, byte_v};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: turns one M-stage access into a single
// bus transaction (IDLE -> REQ -> DONE), stalling the pipeline while it is
// outstanding, with a bus timeout that reports bus_err.
// Optional feature macro: LSU_ALIGN_EXC_EN enables misalignment exceptions;
// when undefined, misaligned low address bits are ignored.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid, lsOp, addr,
//   wdata                      access request from the pipeline
//   stall                      freeze upstream pipeline
//   rdata, rdata_valid         extended load result and completion pulse
//   exc_adel, exc_ades         load/store misalignment exceptions
//   bus_err                    timeout pulse
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata          bus request side
//   mem_ack, mem_rdata         bus response side
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [3:0]  lsOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

  lsu_state_e  state_q;
  logic [3:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] wait_q;
  logic [16:0] wait_inc;
  logic [31:0] ext_data;

  logic        req_legal;
  logic        req_misal;
  logic        accept;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  lsu_load_ext u_load_ext (
    .raw_i     (mem_rdata),
    .op_i      (op_q),
    .addr_lo_i (addr_lo_q),
    .data_o    (ext_data)
  );

  always_comb begin
    req_legal = req_valid && op_is_legal(lsOp);
`ifdef LSU_ALIGN_EXC_EN
    req_misal = req_legal && op_misaligned(lsOp, addr[1:0]);
`else
    req_misal = 1'b0;
`endif
    accept = (state_q == S_IDLE) && req_legal && !req_misal;
  end

  // Gated by rst_n so stall drops immediately on reset even while a
  // request is still presented combinationally.
  assign stall = rst_n && ((state_q == S_REQ) || accept);

`ifdef LSU_ALIGN_EXC_EN
  assign exc_adel = rst_n && (state_q == S_IDLE) && req_misal && op_is_load(lsOp);
  assign exc_ades = rst_n && (state_q == S_IDLE) && req_misal && op_is_store(lsOp);
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  always_comb begin
    be_d = '0;
    wd_d = wdata;
    case (lsOp)
      OP_SW: be_d = 4'b1111;
      OP_SH: begin
        be_d = addr[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{wdata[15:0]}};
      end
      OP_SB: begin
        be_d = 4'b0001 << addr[1:0];
        wd_d = {4{wdata[7:0]}};
      end
      default: be_d = '0;
    endcase
  end

  assign wait_inc = {1'b0, wait_q} + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_lo_q   <= '0;
      wait_q      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_REQ;
            op_q      <= lsOp;
            addr_lo_q <= addr[1:0];
            wait_q    <= '0;
            mem_req   <= 1'b1;
            mem_we    <= op_is_store(lsOp);
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_d;
            mem_wdata <= wd_d;
          end
        end
        S_REQ: begin
          // Ack is checked before the timeout so a same-cycle ack wins.
          if (mem_ack) begin
            if (op_is_load(op_q)) rdata <= ext_data;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            rdata_valid <= 1'b1;
            state_q     <= S_DONE;
          end else if (wait_inc >= TO_LIM) begin
            rdata       <= '0;
            bus_err     <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            rdata_valid <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            wait_q <= wait_inc[15:0];
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  lsOp = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] rexp = '0;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .lsOp        (lsOp),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: pick the addressed field arithmetically and extend it.
  function automatic logic [31:0] model_ext(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] rd);
    logic [31:0] v;
    v = rd;
    if (op == 4'd2 || op == 4'd3) begin
      v = (rd >> (16 * ((a >> 1) & 32'd1))) & 32'hFFFF;
      if (op == 4'd2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else if (op == 4'd4 || op == 4'd5) begin
      v = (rd >> (8 * (a & 32'd3))) & 32'hFF;
      if (op == 4'd4 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] be;
    be = 4'd0;
    if (op == 4'd6) be = 4'd15;
    else if (op == 4'd7) be = a[1] ? 4'd12 : 4'd3;
    else if (op == 4'd8) be = 4'(32'd1 << (a & 32'd3));
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [3:0] op, input logic [31:0] wd);
    logic [31:0] v;
    v = wd;
    if (op == 4'd7) v = (wd & 32'hFFFF) * 32'h0001_0001;
    else if (op == 4'd8) v = (wd & 32'hFF) * 32'h0101_0101;
    return v;
  endfunction

  // One access from IDLE. ack_at = REQ cycle (1-based) in which mem_ack is
  // driven; 0 or anything beyond TO means the bus never answers.
  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int unsigned ack_at);
    logic is_ld, is_st, legal, mis, timed;
    int unsigned nreq, nstall;
    is_ld = (op >= 4'd1) && (op <= 4'd5);
    is_st = (op >= 4'd6) && (op <= 4'd8);
    legal = is_ld || is_st;
    mis = 1'b0;
`ifdef LSU_ALIGN_EXC_EN
    if (op == 4'd1 || op == 4'd6) mis = ((a & 32'd3) != 32'd0);
    else if (op == 4'd2 || op == 4'd3 || op == 4'd7) mis = a[0];
`endif
    req_valid = 1'b1;
    lsOp = op;
    addr = a;
    wdata = wd;
    mem_ack = 1'b0;
    #1;
    nstall = 0;
    if (stall === 1'b1) nstall++;
    check1("idle_stall", stall, legal && !mis);
    check1("exc_adel", exc_adel, legal && mis && is_ld);
    check1("exc_ades", exc_ades, legal && mis && is_st);
    if (!legal || mis) begin
      tick;
      req_valid = 1'b0;
      #1;
      check1("noreq_mem_req", mem_req, 1'b0);
      check1("noreq_stall", stall, 1'b0);
      check1("noreq_valid", rdata_valid, 1'b0);
      return;
    end
    nreq = 0;
    timed = 1'b0;
    for (int unsigned k = 1; k <= TO; k++) begin
      tick;
      nreq++;
      // Scramble the request inputs to confirm the access was latched.
      req_valid = 1'b0;
      lsOp = 4'($urandom);
      addr = $urandom;
      wdata = $urandom;
      mem_ack = (k == ack_at);
      mem_rdata = (k == ack_at) ? rd : $urandom;
      #1;
      if (stall === 1'b1) nstall++;
      check1("req_mem_req", mem_req, 1'b1);
      check1("req_stall", stall, 1'b1);
      check1("req_valid", rdata_valid, 1'b0);
      check32("req_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      check1("req_mem_we", mem_we, is_st);
      check32("req_mem_be", {28'd0, mem_be}, {28'd0, model_be(op, a)});
      if (is_st) check32("req_mem_wdata", mem_wdata, model_wd(op, wd));
      if (k == ack_at) break;
      if (k == TO) timed = 1'b1;
    end
    tick;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (timed) rexp = '0;
    else if (is_ld) rexp = model_ext(op, a, rd);
    #1;
    check1("done_valid", rdata_valid, 1'b1);
    check1("done_stall", stall, 1'b0);
    check1("done_mem_req", mem_req, 1'b0);
    check1("done_bus_err", bus_err, timed);
    check32("done_rdata", rdata, rexp);
    check32("stall_cycles", nstall, 1 + nreq);
    // A request in DONE must be ignored.
    req_valid = 1'b1;
    lsOp = 4'd1;
    addr = 32'h0;
    #1;
    check1("done_ignore_stall", stall, 1'b0);
    tick;
    req_valid = 1'b0;
    #1;
    check1("post_valid", rdata_valid, 1'b0);
    check1("post_bus_err", bus_err, 1'b0);
    check1("post_mem_req", mem_req, 1'b0);
    check32("post_rdata_hold", rdata, rexp);
  endtask

  initial begin
    // Reset with a live request presented: everything must stay quiet.
    rst_n = 1'b0;
    req_valid = 1'b1;
    lsOp = 4'd1;
    addr = 32'h100;
    #3;
    check1("rst_stall", stall, 1'b0);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check1("rst_valid", rdata_valid, 1'b0);
    check1("rst_bus_err", bus_err, 1'b0);
    check1("rst_exc_adel", exc_adel, 1'b0);
    check1("rst_exc_ades", exc_ades, 1'b0);
    check32("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Directed cases.
    do_txn(4'd4, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3);   // lb, 4 stall cycles
    do_txn(4'd7, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1);   // sh upper half
    do_txn(4'd1, 32'h0000_0001, 32'h0, 32'h1234_5678, 2);   // misaligned lw
    do_txn(4'd3, 32'h0000_0002, 32'h0, 32'h0, 0);           // lhu timeout
    do_txn(4'd2, 32'h0000_0042, 32'h0, 32'h9ABC_1234, TO);  // ack on timeout cycle
    do_txn(4'd6, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2);   // sw keeps rdata
    do_txn(4'd8, 32'h0000_0021, 32'h0000_00A5, 32'h0, 1);   // sb lane 1
    do_txn(4'd5, 32'h0000_0002, 32'h0, 32'h00F1_0000, 1);   // lbu
    do_txn(4'd0, 32'h0000_0000, 32'h0, 32'h0, 1);           // no-op
    do_txn(4'd9, 32'h0000_0000, 32'h0, 32'h0, 1);           // reserved code

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      do_txn(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom,
             $urandom_range(0, TO + 1));
    end

    // Reset in the second REQ cycle abandons the access.
    req_valid = 1'b1;
    lsOp = 4'd1;
    addr = 32'h0000_0040;
    #1;
    tick;
    req_valid = 1'b0;
    tick;
    check1("mid_mem_req", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("arst_mem_req", mem_req, 1'b0);
    check1("arst_stall", stall, 1'b0);
    check32("arst_mem_addr", mem_addr, 32'd0);
    check32("arst_rdata", rdata, 32'd0);
    rexp = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check1("after_rst_valid", rdata_valid, 1'b0);
      check1("after_rst_mem_req", mem_req, 1'b0);
    end

    do_txn(4'd1, 32'h0000_0080, 32'h0, 32'h0BAD_F00D, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
